// File: rtl/lif_pkg.sv
// Shared constants and types for the LIF parameter loader: frame layout,
// reset values of the committed parameter set and the loader FSM encoding.
package lif_pkg;

  localparam int unsigned FRAME_BITS = 24;

  // Field widths within the configuration frame
  localparam int unsigned THR_W    = 8;
  localparam int unsigned WGT_W    = 6;
  localparam int unsigned LEAK_W   = 4;
  localparam int unsigned REFRAC_W = 4;

  // Field LSB offsets; bits [1:0] are reserved and ignored
  localparam int unsigned THR_LSB    = 16;
  localparam int unsigned WGT_LSB    = 10;
  localparam int unsigned LEAK_LSB   = 6;
  localparam int unsigned REFRAC_LSB = 2;

  // Values restored by reset
  localparam logic [THR_W-1:0]    DEF_THRESHOLD = 8'd100;
  localparam logic [WGT_W-1:0]    DEF_WEIGHT    = 6'd8;
  localparam logic [LEAK_W-1:0]   DEF_LEAK      = 4'd1;
  localparam logic [REFRAC_W-1:0] DEF_REFRAC    = 4'd2;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StCommit
  } lif_state_e;

endpackage

// File: rtl/lif_sync_bit.sv
// Single-bit flop synchroniser, STAGES deep, with synchronous reset.
// The chain freezes while enable is low so that bits already in flight are
// not lost or replaced during a stall.
module lif_sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic enable_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the input through the synchroniser chain
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '0;
    end else if (enable_i) begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/lif_param_loader.sv
// Serial configuration front-end for the LIF neuron core. Collects a frame
// MSB first while load_mode is high and commits it atomically into the
// shadow parameter set only if exactly FRAME_BITS bits were received.
module lif_param_loader #(
  parameter int unsigned FRAME_BITS    = lif_pkg::FRAME_BITS,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter logic [7:0]  DEF_THRESHOLD = lif_pkg::DEF_THRESHOLD,
  parameter logic [5:0]  DEF_WEIGHT    = lif_pkg::DEF_WEIGHT,
  parameter logic [3:0]  DEF_LEAK      = lif_pkg::DEF_LEAK,
  parameter logic [3:0]  DEF_REFRAC    = lif_pkg::DEF_REFRAC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       load_mode,
  input  logic       serial_data,
  output logic [7:0] threshold,
  output logic [5:0] weight_a,
  output logic [3:0] leak_rate,
  output logic [3:0] refrac_period,
  output logic       params_ready,
  output logic       param_update,
  output logic       frame_err
);

  import lif_pkg::*;

  // Counter must hold FRAME_BITS+1 to flag an overrun
  localparam int unsigned    CntW    = $clog2(FRAME_BITS + 2);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntFull = CntW'(FRAME_BITS);
  localparam logic [CntW-1:0] CntSat  = CntW'(FRAME_BITS + 1);

  lif_state_e            state_q, state_d;
  logic                  lm_s, sd_s;
  logic [FRAME_BITS-1:0] shift_q;
  logic [CntW-1:0]       cnt_q;
  logic                  valid_seen_q;
  logic                  commit_ok_q;

  lif_sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_sync_lm (
    .clk_i   (clk),
    .reset_i (reset),
    .enable_i(enable),
    .d_i     (load_mode),
    .q_o     (lm_s)
  );

  lif_sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_sync_sd (
    .clk_i   (clk),
    .reset_i (reset),
    .enable_i(enable),
    .d_i     (serial_data),
    .q_o     (sd_s)
  );

  // FSM state register; frozen while enable is low
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else if (enable) begin
      state_q <= state_d;
    end
  end

  // FSM next-state: frame envelope follows lm_s, COMMIT lasts one cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (lm_s)  state_d = StShift;
      StShift:  if (!lm_s) state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs: pulse only while sitting in COMMIT after a good frame
  always_comb begin
    param_update = 1'b0;
    if (state_q == StCommit) begin
      param_update = commit_ok_q;
    end
  end

  // Datapath: bit collection, counting and the atomic shadow update. The
  // first bit arrives together with the envelope, so it is captured on
  // leaving IDLE. The shadow set is written on the edge entering COMMIT so
  // that new values and param_update become visible together.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q       <= '0;
      cnt_q         <= '0;
      valid_seen_q  <= 1'b0;
      commit_ok_q   <= 1'b0;
      frame_err     <= 1'b0;
      params_ready  <= 1'b0;
      threshold     <= DEF_THRESHOLD;
      weight_a      <= DEF_WEIGHT;
      leak_rate     <= DEF_LEAK;
      refrac_period <= DEF_REFRAC;
    end else if (enable) begin
      unique case (state_q)
        StIdle: begin
          if (lm_s) begin
            shift_q      <= {shift_q[FRAME_BITS-2:0], sd_s};
            cnt_q        <= CntOne;
            frame_err    <= 1'b0;
            params_ready <= 1'b0;
          end
        end
        StShift: begin
          if (lm_s) begin
            shift_q <= {shift_q[FRAME_BITS-2:0], sd_s};
            if (cnt_q != CntSat) begin
              cnt_q <= cnt_q + CntOne;
            end
          end else begin
            commit_ok_q <= (cnt_q == CntFull);
            if (cnt_q == CntFull) begin
              threshold     <= shift_q[THR_LSB +: THR_W];
              weight_a      <= shift_q[WGT_LSB +: WGT_W];
              leak_rate     <= shift_q[LEAK_LSB +: LEAK_W];
              refrac_period <= shift_q[REFRAC_LSB +: REFRAC_W];
              params_ready  <= 1'b1;
              valid_seen_q  <= 1'b1;
            end else begin
              frame_err    <= 1'b1;
              params_ready <= valid_seen_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
